// File: rtl/hpi_pkg.sv
// Shared definitions for the EZ-OTG host port interface cycle sequencer.
//   hpi_state_t : bus-cycle sequencer states
//   HPI_*       : HPI register addresses as seen on otg_hpi_address
//   HPI_CNT_W   : width of the per-state down-counter
package hpi_pkg;

  localparam int HPI_CNT_W = 4;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RECOV  = 3'd4
  } hpi_state_t;

endpackage

// File: rtl/hpi_cycle_ctrl_if.sv
// Register-level request/response channel of the HPI cycle sequencer.
//   req_valid/req_ready : handshake, transfer on a clk edge with both high
//   req_write           : 1 = write, 0 = read
//   req_addr            : HPI register address
//   req_wdata           : write data
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata           : last read data, held until the next read completes
// Modports: master = requester (PIO register block), slave = sequencer.
interface hpi_cycle_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/hpi_int_sync.sv
// Interrupt synchronizer and rising-edge detector for otg_hpi_int.
//   clk, reset : system clock, synchronous active-high reset
//   async_in   : asynchronous interrupt from the OTG chip
//   rise       : one-cycle pulse, registered, three edges after async_in rises
module hpi_int_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  // [0],[1] form the two-flop synchronizer; [2] is the edge-history register.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      rise   <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/hpi_cycle_ctrl.sv
// HPI bus-cycle sequencer: turns one register-level request into a complete,
// timed EZ-OTG HPI cycle (SETUP -> STROBE -> HOLD -> RECOV) and returns read
// data with a completion pulse.
//   clk, reset        : system clock, synchronous active-high reset
//   bus               : request/response channel (slave modport)
//   otg_hpi_address   : HPI address pins
//   otg_hpi_cs_n      : chip select, active low
//   otg_hpi_r_n/_w_n  : read / write strobes, active low
//   otg_hpi_data_out  : write data to the pad
//   otg_hpi_data_oe   : pad output enable
//   otg_hpi_data_in   : read data from the pad
//   otg_hpi_int       : asynchronous chip interrupt
//   hpi_int_rise      : one-cycle pulse per interrupt rising edge
// Parameters SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVERY_CYC: cycles spent in
// each timed state, each 1..15.
// Optional build macro HPI_INT_SYNC_EN: enables the interrupt synchronizer;
// when undefined hpi_int_rise is tied low and otg_hpi_int is ignored.
module hpi_cycle_ctrl
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  hpi_cycle_ctrl_if.slave     bus,
  output logic [1:0]          otg_hpi_address,
  output logic                otg_hpi_cs_n,
  output logic                otg_hpi_r_n,
  output logic                otg_hpi_w_n,
  output logic [15:0]         otg_hpi_data_out,
  output logic                otg_hpi_data_oe,
  input  logic [15:0]         otg_hpi_data_in,
  input  logic                otg_hpi_int,
  output logic                hpi_int_rise
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15 || RECOVERY_CYC < 1 || RECOVERY_CYC > 15) begin : g_bad_param
    $error("hpi_cycle_ctrl: timing parameters must each be in 1..15");
  end

  localparam logic [HPI_CNT_W-1:0] SETUP_LD  = HPI_CNT_W'(SETUP_CYC);
  localparam logic [HPI_CNT_W-1:0] STROBE_LD = HPI_CNT_W'(STROBE_CYC);
  localparam logic [HPI_CNT_W-1:0] HOLD_LD   = HPI_CNT_W'(HOLD_CYC);
  localparam logic [HPI_CNT_W-1:0] RECOV_LD  = HPI_CNT_W'(RECOVERY_CYC);
  localparam logic [HPI_CNT_W-1:0] CNT_ONE   = HPI_CNT_W'(1);

  hpi_state_t             state_q, state_nxt;
  logic [HPI_CNT_W-1:0]   cnt_q, cnt_nxt;
  logic                   wr_q, wr_nxt;
  logic                   accept;
  logic                   busy_nxt;
  logic                   strobe_nxt;
  logic                   capture;
  logic                   rsp_nxt;

  logic [1:0]             addr_q;
  logic                   cs_n_q, r_n_q, w_n_q, oe_q;
  logic [15:0]            dout_q;
  logic [15:0]            rdata_q;
  logic                   rsp_valid_q;
  logic                   ready_q;

  // Next-state and next-pin decode. Every pin is registered from these, so
  // the pads always see the state being entered, never a decode of req_*.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_ONE) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNT_ONE) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_ONE) begin
          state_nxt = ST_RECOV;
          cnt_nxt   = RECOV_LD;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      ST_RECOV: begin
        if (cnt_q == CNT_ONE) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    wr_nxt     = accept ? bus.req_write : wr_q;
    busy_nxt   = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                 (state_nxt == ST_HOLD);
    strobe_nxt = (state_nxt == ST_STROBE);
    // Read data is sampled on the edge that closes the last strobe cycle,
    // while r_n is still low at the pad.
    capture    = (state_q == ST_STROBE) && (state_nxt == ST_HOLD) && !wr_q;
    rsp_nxt    = (state_q == ST_HOLD) && (state_nxt == ST_RECOV);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      cs_n_q      <= 1'b1;
      r_n_q       <= 1'b1;
      w_n_q       <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      wr_q        <= wr_nxt;
      cs_n_q      <= !busy_nxt;
      r_n_q       <= !(strobe_nxt && !wr_nxt);
      w_n_q       <= !(strobe_nxt && wr_nxt);
      oe_q        <= busy_nxt && wr_nxt;
      rsp_valid_q <= rsp_nxt;
      ready_q     <= (state_nxt == ST_IDLE);
      if (accept) begin
        addr_q <= bus.req_addr;
        if (bus.req_write) begin
          dout_q <= bus.req_wdata;
        end
      end
      if (capture) begin
        rdata_q <= otg_hpi_data_in;
      end
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rdata_q;
  assign otg_hpi_address   = addr_q;
  assign otg_hpi_cs_n      = cs_n_q;
  assign otg_hpi_r_n       = r_n_q;
  assign otg_hpi_w_n       = w_n_q;
  assign otg_hpi_data_out  = dout_q;
  assign otg_hpi_data_oe   = oe_q;

`ifdef HPI_INT_SYNC_EN
  hpi_int_sync u_int_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (otg_hpi_int),
    .rise     (hpi_int_rise)
  );
`else
  logic unused_int;
  assign unused_int   = otg_hpi_int;
  assign hpi_int_rise = 1'b0;
`endif

endmodule

// File: tb/tb_hpi_cycle_ctrl.sv
// Testbench for hpi_cycle_ctrl: two instances (default timing and
// SETUP=3/STROBE=1/HOLD=2/RECOVERY=1), randomized and directed requests,
// checked cycle by cycle against a timeline model derived from S/T/H/R.
module tb_hpi_cycle_ctrl;
  import hpi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv, rw;
  logic [1:0]  ra;
  logic [15:0] rd;
  logic [15:0] pad_val;
  logic        int_in;
  bit          sel;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int S, T, H, R;
  logic [15:0] last_rdata [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hpi_cycle_ctrl_if if0 ();
  hpi_cycle_ctrl_if if1 ();

  assign if0.req_valid = rv & ~sel;
  assign if0.req_write = rw;
  assign if0.req_addr  = ra;
  assign if0.req_wdata = rd;
  assign if1.req_valid = rv & sel;
  assign if1.req_write = rw;
  assign if1.req_addr  = ra;
  assign if1.req_wdata = rd;

  logic [1:0]  addr0, addr1;
  logic        cs_n0, cs_n1, r_n0, r_n1, w_n0, w_n1, oe0, oe1, ir0, ir1;
  logic [15:0] dout0, dout1, din0, din1;

  // Pad model: the chip only drives valid read data while r_n is low.
  assign din0 = !r_n0 ? pad_val : 16'hDEAD;
  assign din1 = !r_n1 ? pad_val : 16'hDEAD;

  hpi_cycle_ctrl u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave),
    .otg_hpi_address(addr0), .otg_hpi_cs_n(cs_n0), .otg_hpi_r_n(r_n0),
    .otg_hpi_w_n(w_n0), .otg_hpi_data_out(dout0), .otg_hpi_data_oe(oe0),
    .otg_hpi_data_in(din0), .otg_hpi_int(int_in), .hpi_int_rise(ir0)
  );

  hpi_cycle_ctrl #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .RECOVERY_CYC(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave),
    .otg_hpi_address(addr1), .otg_hpi_cs_n(cs_n1), .otg_hpi_r_n(r_n1),
    .otg_hpi_w_n(w_n1), .otg_hpi_data_out(dout1), .otg_hpi_data_oe(oe1),
    .otg_hpi_data_in(din1), .otg_hpi_int(int_in), .hpi_int_rise(ir1)
  );

  logic [1:0]  o_addr;
  logic        o_cs_n, o_r_n, o_w_n, o_oe, o_rsp, o_ready, o_ir;
  logic [15:0] o_dout, o_rdata;
  assign o_addr  = sel ? addr1 : addr0;
  assign o_cs_n  = sel ? cs_n1 : cs_n0;
  assign o_r_n   = sel ? r_n1  : r_n0;
  assign o_w_n   = sel ? w_n1  : w_n0;
  assign o_oe    = sel ? oe1   : oe0;
  assign o_dout  = sel ? dout1 : dout0;
  assign o_rsp   = sel ? if1.rsp_valid : if0.rsp_valid;
  assign o_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
  assign o_ready = sel ? if1.req_ready : if0.req_ready;
  assign o_ir    = sel ? ir1 : ir0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic use_dut(input bit s);
    sel = s;
    if (!s) begin S = 1; T = 4; H = 1; R = 2; end
    else    begin S = 3; T = 1; H = 2; R = 1; end
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, " cs_n"},  {15'd0, o_cs_n}, 16'd1);
    chk({pfx, " r_n"},   {15'd0, o_r_n},  16'd1);
    chk({pfx, " w_n"},   {15'd0, o_w_n},  16'd1);
    chk({pfx, " oe"},    {15'd0, o_oe},   16'd0);
    chk({pfx, " addr"},  {14'd0, o_addr}, 16'd0);
    chk({pfx, " dout"},  o_dout,          16'd0);
    chk({pfx, " rsp"},   {15'd0, o_rsp},  16'd0);
    chk({pfx, " rdata"}, o_rdata,         16'd0);
    chk({pfx, " ready"}, {15'd0, o_ready}, 16'd1);
    chk({pfx, " irise"}, {15'd0, o_ir},   16'd0);
  endtask

  // Waits (bounded) for req_ready, performs the accept edge; returns at #1
  // after it. ok=0 when the bound expired.
  task automatic do_accept(output int acc, output bit ok);
    int n = 0;
    while (o_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    ok = (n < 40);
    if (!ok) chk("ready_timeout", {15'd0, o_ready}, 16'd1);
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  // One full transaction. Called at #1 after a posedge; returns at #1 after
  // the edge on which the controller is back in IDLE (k = P).
  task automatic run_txn(input logic w, input logic [1:0] a, input logic [15:0] d,
                         input logic [15:0] pv, input bit keep, output int acc);
    int  p, act;
    bit  ok;
    logic [15:0] old_rd, new_rd;
    string tg;
    rv = 1'b1; rw = w; ra = a; rd = d; pad_val = pv;
    do_accept(acc, ok);
    if (!ok) begin rv = 1'b0; return; end
    if (!keep) rv = 1'b0;
    // Request inputs must be ignored once accepted.
    rw = 1'($urandom); ra = 2'($urandom); rd = 16'($urandom);
    p      = 1 + S + T + H + R;
    act    = S + T + H;
    old_rd = last_rdata[sel];
    new_rd = w ? old_rd : pv;
    for (int k = 1; k <= p; k++) begin
      tg = $sformatf("d%0d %s k=%0d", sel, w ? "wr" : "rd", k);
      chk({tg, " cs_n"}, {15'd0, o_cs_n}, {15'd0, !(k <= act)});
      chk({tg, " w_n"},  {15'd0, o_w_n},  {15'd0, !(w && k > S && k <= S + T)});
      chk({tg, " r_n"},  {15'd0, o_r_n},  {15'd0, !(!w && k > S && k <= S + T)});
      chk({tg, " oe"},   {15'd0, o_oe},   {15'd0, (w && k <= act)});
      if (k < p) chk({tg, " addr"}, {14'd0, o_addr}, {14'd0, a});
      if (w && k <= act) chk({tg, " dout"}, o_dout, d);
      chk({tg, " rsp"},   {15'd0, o_rsp},   {15'd0, (k == act + 1)});
      chk({tg, " ready"}, {15'd0, o_ready}, {15'd0, (k == p)});
      chk({tg, " rdata"}, o_rdata, (k > S + T) ? new_rd : old_rd);
      chk({tg, " irise"}, {15'd0, o_ir}, 16'd0);
      if (k < p) begin @(posedge clk); #1; end
    end
    last_rdata[sel] = new_rd;
  endtask

  initial begin
    int a0, a1, a2, ir_cnt, ir_first;
    bit ok;
    reset = 1'b1; rv = 1'b0; rw = 1'b0; ra = '0; rd = '0; pad_val = '0; int_in = 1'b0;
    use_dut(1'b0);
    last_rdata[0] = '0; last_rdata[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst d0");
    use_dut(1'b1);
    chk_reset_state("rst d1");
    reset = 1'b0;
    use_dut(1'b0);
    @(posedge clk); #1;

    // Directed write and read with default timing.
    run_txn(1'b1, HPI_ADDRESS, 16'hA5C3, 16'h0000, 1'b0, a0);
    run_txn(1'b0, HPI_DATA, 16'h0000, 16'h1234, 1'b0, a0);

    // Randomized requests with random idle gaps.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      run_txn(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 1'b0, a0);
    end

    // req_valid held high: one accept per period, never a duplicate.
    run_txn(1'b1, HPI_MAILBOX, 16'($urandom), 16'h0, 1'b1, a0);
    run_txn(1'b0, HPI_STATUS,  16'h0, 16'($urandom), 1'b1, a1);
    run_txn(1'b1, HPI_DATA,    16'($urandom), 16'h0, 1'b0, a2);
    chk("b2b gap1", 16'(a1 - a0), 16'd9);
    chk("b2b gap2", 16'(a2 - a1), 16'd9);

    // Alternate timing parameters.
    use_dut(1'b1);
    run_txn(1'b1, 2'($urandom), 16'($urandom), 16'h0, 1'b0, a0);
    run_txn(1'b0, 2'($urandom), 16'h0, 16'($urandom), 1'b1, a0);
    run_txn(1'b0, 2'($urandom), 16'h0, 16'($urandom), 1'b0, a1);
    chk("alt b2b gap", 16'(a1 - a0), 16'd8);
    use_dut(1'b0);

    // Reset during the strobe of a write: aborted, no completion.
    rv = 1'b1; rw = 1'b1; ra = HPI_ADDRESS; rd = 16'hBEEF;
    do_accept(a0, ok);
    rv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort w_n t3", {15'd0, o_w_n}, 16'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_rdata[0] = '0; last_rdata[1] = '0;
    chk_reset_state("abort");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort quiet rsp %0d", i), {15'd0, o_rsp}, 16'd0);
      chk($sformatf("abort quiet cs_n %0d", i), {15'd0, o_cs_n}, 16'd1);
    end
    run_txn(1'b0, HPI_DATA, 16'h0, 16'($urandom), 1'b0, a0);

    // Interrupt path.
`ifdef HPI_INT_SYNC_EN
    #2 int_in = 1'b1;
    ir_cnt = 0; ir_first = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (o_ir === 1'b1) begin
        ir_cnt++;
        if (ir_first == 0) ir_first = i;
      end
    end
    chk("int pulse count", 16'(ir_cnt), 16'd1);
    chk("int pulse latency", 16'(ir_first), 16'd3);
    int_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`else
    ir_cnt = 0; ir_first = 0;
    for (int i = 0; i < 12; i++) begin
      int_in = 1'($urandom);
      @(posedge clk); #1;
      if (o_ir !== 1'b0) ir_cnt++;
    end
    chk("int tied low", 16'(ir_cnt), 16'd0);
    int_in = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
